// File: rtl/data_memory.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : data_memory
// Description : Fixed-latency block memory behind the data cache; one-cycle ack.
// Revision    : 1.0
// ============================================================================
module data_memory #(
  parameter int DEPTH   = 512,
  parameter int DATA_W  = 256,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic              ack_o,
  output logic [DATA_W-1:0] data_o
);

  localparam int c_IDX_W = $clog2(DEPTH);
  localparam int c_OFF_W = $clog2(DATA_W / 8);
  localparam int c_CNT_W = $clog2(LATENCY + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = LATENCY[c_CNT_W-1:0];

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  logic [DATA_W-1:0]  memory [DEPTH];

  state_t             r_state;
  logic [c_CNT_W-1:0] r_count;
  logic [c_IDX_W-1:0] r_idx;
  logic [DATA_W-1:0]  r_wdata;
  logic               r_write;

  state_t             w_state_nxt;
  logic [c_CNT_W-1:0] w_count_nxt;
  logic               w_ack_nxt;
  logic [DATA_W-1:0]  w_data_nxt;
  logic               w_accept;
  logic               w_commit;
  logic               w_unused;

  assign w_unused = ^{addr_i[ADDR_W-1:c_OFF_W+c_IDX_W], addr_i[c_OFF_W-1:0]};

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_ack_nxt   = 1'b0;
    w_data_nxt  = '0;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable_i) begin
          w_accept    = 1'b1;
          w_count_nxt = c_CNT_ONE;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // Counter reaches LATENCY on the cycle before the ack edge.
        if (r_count == c_CNT_LAST) begin
          w_state_nxt = S_ACK;
          w_ack_nxt   = 1'b1;
          w_commit    = r_write;
          w_data_nxt  = r_write ? r_wdata : memory[r_idx];
          w_count_nxt = '0;
        end else begin
          w_count_nxt = r_count + c_CNT_ONE;
        end
      end
      S_ACK: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
      ack_o   <= 1'b0;
      data_o  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      ack_o   <= w_ack_nxt;
      data_o  <= w_data_nxt;
      if (w_accept) begin
        r_idx   <= addr_i[c_OFF_W +: c_IDX_W];
        r_wdata <= data_i;
        r_write <= write_i;
      end
    end
  end

  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk_i) begin
    if (w_commit) begin
      memory[r_idx] <= r_wdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_memory.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_data_memory
// Description : Directed plus randomized bench for data_memory with array model.
// Revision    : 1.0
// ============================================================================
module tb_data_memory;

  localparam int DEPTH   = 512;
  localparam int DATA_W  = 256;
  localparam int ADDR_W  = 32;
  localparam int LATENCY = 10;
  localparam int T       = 10;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] data_i;
  logic              enable_i;
  logic              write_i;
  logic              ack_o;
  logic [DATA_W-1:0] data_o;

  logic [DATA_W-1:0] ref_mem [DEPTH];
  int                n_chk  = 0;
  int                n_pass = 0;
  int                n_fail = 0;
  time               last_ack;

  data_memory #(
    .DEPTH   (DEPTH),
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .LATENCY (LATENCY)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .addr_i   (addr_i),
    .data_i   (data_i),
    .enable_i (enable_i),
    .write_i  (write_i),
    .ack_o    (ack_o),
    .data_o   (data_o)
  );

  always #(T/2) clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand256();
    logic [DATA_W-1:0] v;
    for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One full transaction, called in the low phase of an IDLE cycle.
  // Inputs are deliberately disturbed after acceptance.
  task automatic run_txn(input string tag, input bit wr, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, input bit keep_en);
    int                idx;
    logic [DATA_W-1:0] exp;
    idx      = int'((addr >> 5) % DEPTH);
    enable_i = 1'b1;
    write_i  = wr;
    addr_i   = addr;
    data_i   = wdata;
    @(posedge clk_i);
    if (wr) ref_mem[idx] = wdata;
    exp = ref_mem[idx];
    @(negedge clk_i);
    enable_i = keep_en;
    write_i  = ~wr;
    addr_i   = addr + 32'h20;
    data_i   = rand256();
    for (int k = 1; k <= LATENCY; k++) begin
      @(posedge clk_i);
      #1;
      if (k < LATENCY) begin
        chk({tag, "_ack_wait"}, DATA_W'(ack_o), '0);
        chk({tag, "_data_wait"}, data_o, '0);
      end else begin
        last_ack = $time;
        chk({tag, "_ack"}, DATA_W'(ack_o), DATA_W'(1));
        chk({tag, "_data"}, data_o, exp);
      end
    end
    @(posedge clk_i);
    #1;
    chk({tag, "_ack_end"}, DATA_W'(ack_o), '0);
    chk({tag, "_data_end"}, data_o, '0);
    @(negedge clk_i);
  endtask

  task automatic check_idle(input string tag, input int n);
    enable_i = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk_i);
      #1;
      chk(tag, DATA_W'(ack_o), '0);
    end
    @(negedge clk_i);
  endtask

  initial begin
    time t_first;
    rst_i    = 1'b1;
    enable_i = 1'b1;
    write_i  = 1'b0;
    addr_i   = '0;
    data_i   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = rand256();
      dut.memory[i] <= ref_mem[i];
    end
    ref_mem[0] = 256'd5;
    ref_mem[1] = 256'hABCD;
    dut.memory[0] <= 256'd5;
    dut.memory[1] <= 256'hABCD;

    // Reset held with a request pending
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_ack", DATA_W'(ack_o), '0);
    chk("reset_data", data_o, '0);
    @(negedge clk_i);
    enable_i = 1'b0;
    rst_i    = 1'b0;
    chk("mem0_after_reset", dut.memory[0], 256'd5);

    // Read latency, then write-then-read through block 32
    run_txn("read_0x20", 1'b0, 32'h20, '0, 1'b0);
    run_txn("write_0x400", 1'b1, 32'h400, 256'h1234, 1'b0);
    chk("mem32_written", dut.memory[32], 256'h1234);
    run_txn("read_0x400", 1'b0, 32'h400, '0, 1'b0);

    // Inputs disturbed during WAIT; nothing else may start afterwards
    run_txn("stable_0x20", 1'b0, 32'h20, '0, 1'b0);
    check_idle("no_second_txn", LATENCY + 3);

    // Back-to-back with enable held high
    run_txn("b2b_0x00", 1'b0, 32'h00, '0, 1'b1);
    t_first = last_ack;
    run_txn("b2b_0x20", 1'b0, 32'h20, '0, 1'b0);
    chk("b2b_spacing", DATA_W'(last_ack - t_first), DATA_W'((LATENCY + 2) * T));

    // Reset during WAIT of a write aborts it
    enable_i = 1'b1;
    write_i  = 1'b1;
    addr_i   = 32'h60;
    data_i   = 256'hFF;
    @(posedge clk_i);
    @(negedge clk_i);
    enable_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("abort_ack", DATA_W'(ack_o), '0);
    chk("abort_data", data_o, '0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    check_idle("abort_no_ack", LATENCY + 3);
    chk("abort_mem3", dut.memory[3], ref_mem[3]);

    // 0x4000 aliases block 0
    run_txn("alias_0x4000", 1'b1, 32'h4000, 256'hC0FFEE, 1'b0);
    chk("alias_mem0", dut.memory[0], 256'hC0FFEE);
    run_txn("alias_read_0x0", 1'b0, 32'h0, '0, 1'b0);

    // Randomized traffic against the array model
    for (int n = 0; n < 24; n++) begin
      logic [ADDR_W-1:0] a;
      bit                w;
      bit                hold;
      a    = $urandom;
      if (n % 3 == 1) a = {$urandom_range(0, 7), 5'b0} | ($urandom & 32'hFFFF_C01F);
      w    = 1'($urandom_range(0, 1));
      hold = (n < 23) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_txn($sformatf("rand%0d", n), w, a, rand256(), hold);
    end
    for (int b = 0; b < 8; b++) begin
      run_txn($sformatf("sweep%0d", b), 1'b0, 32'(b * 32), '0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
